pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic parametrised inter-stage pipeline register for the 5-stage MIPS core, the successor to the fixed IF/ID latch. It carries LANES × (instruction, PC, lane-valid) bundles between any two stages using a valid/ready handshake. A one-entry skid slot keeps `in_ready` registered, and the block supports legacy `hold` (stall) and synchronous `flush` (branch/jump squash).

## Interface
- `INST_W`, 32, instruction width per lane
- `PC_W`, 32, PC width per lane
- `LANES`, 1, parallel issue lanes sharing one handshake (≥1)
- `CNT_W`, 32, perf counter width (used only with `PIPE_STAGE_PERF_EN`)

Ports:
- `CLK` in 1: clock, rising edge
- `Reset` in 1: synchronous, active-high
- `in_valid` in 1: upstream bundle valid
- `in_ready` out 1: stage can accept; registered
- `in_lane_v` in LANES: per-lane valid mask
- `in_inst` in LANES*INST_W: lane i at bits [i*INST_W +: INST_W]
- `in_pc` in LANES*PC_W: same packing
- `out_valid` out 1: bundle valid
- `out_ready` in 1: downstream accepts
- `out_lane_v` out LANES
- `out_inst` out LANES*INST_W
- `out_pc` out LANES*PC_W
- `hold` in 1: stall; blocks emission
- `flush` in 1: squash all contents
- `stall_cnt` out CNT_W: see Configuration
- `flush_cnt` out CNT_W: see Configuration

## Operation
- Two slots: main M (drives outputs) and skid S. Each slot holds valid, lane_v, inst, pc.
- accept = `in_valid & in_ready`; emit = `out_valid & out_ready & ~hold`.
- `in_ready` = ~S.valid, registered.
- State machine, defined by (M.valid, S.valid):
  - EMPTY (0,0): accept → M←in, go to ONE.
  - ONE (1,0):
    - accept & emit → M←in, stay in ONE.
    - accept & ~emit → S←in, go to FULL.
    - emit only → go to EMPTY.
  - FULL (1,1): no accept is possible. emit → M←S, S cleared, go to ONE.
- `flush`:
  - Next state is EMPTY. All valids and lane_v are cleared; inst/pc of both slots are set to NOP (32'h0).
  - Any beat accepted in the flush cycle is discarded.
  - Priority: `Reset` > `flush` > normal operation. `hold` has no effect on a flush.
- A slot that goes invalid has its payload cleared to NOP/0, so `out_inst` is never stale while `out_valid`=0.
- Lane data is passed through unmodified; lane_v is not interpreted.

## Timing
- Reset values: `out_valid`=0, `out_lane_v`=0, `out_inst`=0, `out_pc`=0, `in_ready`=1, counters=0.
- Latency in→out: 1 cycle from EMPTY or ONE-with-emit. A beat parked in S adds 1 cycle.
- Throughput: 1 bundle/cycle sustained with `out_ready`=1 and `hold`=0.
- `in_ready` falls the cycle after entering FULL and rises the cycle after leaving it. Upstream may present data while `in_ready`=0; it is not taken.
- `Reset` or `flush` asserted in FULL with `out_ready`=1: nothing is emitted into the next stage's state.
- Ordering is strictly FIFO and no bundle is duplicated.

## Configuration
- Macro: `PIPE_STAGE_PERF_EN`.
- When defined:
  - `stall_cnt` increments each cycle `out_valid & ~emit`.
  - `flush_cnt` increments each `flush` cycle with M.valid|S.valid.
  - Both counters saturate at all-ones and are cleared by `Reset` only.
- When undefined: counter registers are not built and both ports are tied to 0.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum `{EMPTY, ONE, FULL}`
  - `NOP_INST` = 32'h0
  - default widths `INST_W_DEF`, `PC_W_DEF`
- Sub-module `pipe_slot`: one slot (valid + lane_v + inst + pc) with load/clear inputs, instantiated twice (M, S).

## Test plan
- Reset sequence: `Reset`=1 for 2 cycles, then released → `out_valid`=0, `in_ready`=1, `out_inst`=0.
- Streaming: LANES=2, 4 back-to-back beats with pc 0x0,0x4,0x8,0xC; `out_ready`=1 → each appears exactly 1 cycle later, in order, `in_ready` stays 1.
- Backpressure:
  - Drop `out_ready` after beat 0x4 while beats 0x8,0xC are offered → 0x8 parks in S and `in_ready`=0 next cycle; 0xC is not taken.
  - Raise `out_ready` → 0x4, 0x8, 0xC emerge in order with no loss or duplication.
- Hold: assert `hold` 3 cycles with `out_ready`=1 → output frozen, `stall_cnt`=3 (with macro).
- Flush in FULL, with `in_valid`=1 in the same cycle → next cycle `out_valid`=0, `in_ready`=1, `out_inst`=0, `flush_cnt`=1; the offered beat never appears.
- Saturation: CNT_W=4 with a 20-cycle stall → `stall_cnt` holds at 4'hF.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register.
// Holds the occupancy state encoding, the NOP pattern and default widths.
package pipe_pkg;

  // Occupancy of the (main, skid) slot pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd3
  } state_t;

  // Instruction pattern used to scrub slots that go invalid.
  localparam logic [31:0] NOP_INST = 32'h0;

  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF   = 32;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one storage slot (valid, lane mask, instructions, PCs).
// A slot that is cleared or reset goes invalid and its payload is scrubbed
// to NOP/0 so downstream never observes stale data behind a low valid.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    clear,
  input  logic [LANES-1:0]        new_lane_v,
  input  logic [LANES*INST_W-1:0] new_inst,
  input  logic [LANES*PC_W-1:0]   new_pc,
  output logic                    valid,
  output logic [LANES-1:0]        lane_v,
  output logic [LANES*INST_W-1:0] inst,
  output logic [LANES*PC_W-1:0]   pc
);

  // Clear wins over load so a squash can never be overridden by new data.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid  <= 1'b0;
      lane_v <= '0;
      inst   <= {LANES{INST_W'(NOP_INST)}};
      pc     <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      lane_v <= new_lane_v;
      inst   <= new_inst;
      pc     <= new_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register with a one-entry
// skid slot, legacy hold (stall) and synchronous flush (squash).
// Optional performance counters are built only when PIPE_STAGE_PERF_EN is
// defined; otherwise stall_cnt and flush_cnt are tied to zero.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int LANES  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_v,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES*PC_W-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_v,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [LANES*PC_W-1:0]   out_pc,
  input  logic                    hold,
  input  logic                    flush,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  state_t state;

  logic accept;
  logic emit;

  logic m_valid;
  logic m_load;
  logic m_clear;
  logic m_from_s;
  logic [LANES-1:0]        m_new_lane_v;
  logic [LANES*INST_W-1:0] m_new_inst;
  logic [LANES*PC_W-1:0]   m_new_pc;

  logic s_valid;
  logic s_load;
  logic s_clear;
  logic [LANES-1:0]        s_lane_v;
  logic [LANES*INST_W-1:0] s_inst;
  logic [LANES*PC_W-1:0]   s_pc;

  assign accept    = in_valid & in_ready;
  assign emit      = m_valid & out_ready & ~hold;
  assign out_valid = m_valid;

  // Main slot refills from the skid slot when draining FULL, else from input.
  assign m_new_lane_v = m_from_s ? s_lane_v : in_lane_v;
  assign m_new_inst   = m_from_s ? s_inst   : in_inst;
  assign m_new_pc     = m_from_s ? s_pc     : in_pc;

  // Slot load/clear strobes derived from occupancy; flush scrubs both slots.
  always_comb begin
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_clear  = flush;
    s_load   = 1'b0;
    s_clear  = flush;
    if (!flush) begin
      case (state)
        EMPTY: begin
          if (accept) m_load = 1'b1;
        end
        ONE: begin
          if (accept && emit)     m_load  = 1'b1;
          else if (accept)        s_load  = 1'b1;
          else if (emit)          m_clear = 1'b1;
        end
        FULL: begin
          if (emit) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
          end
        end
        default: begin
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  // Occupancy FSM; in_ready is registered and low exactly while FULL.
  always_ff @(posedge CLK) begin
    if (Reset || flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= ONE;
        end
        ONE: begin
          if (accept && !emit) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (!accept && emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(
    .INST_W (INST_W),
    .PC_W   (PC_W),
    .LANES  (LANES)
  ) u_main (
    .clk        (CLK),
    .reset      (Reset),
    .load       (m_load),
    .clear      (m_clear),
    .new_lane_v (m_new_lane_v),
    .new_inst   (m_new_inst),
    .new_pc     (m_new_pc),
    .valid      (m_valid),
    .lane_v     (out_lane_v),
    .inst       (out_inst),
    .pc         (out_pc)
  );

  pipe_slot #(
    .INST_W (INST_W),
    .PC_W   (PC_W),
    .LANES  (LANES)
  ) u_skid (
    .clk        (CLK),
    .reset      (Reset),
    .load       (s_load),
    .clear      (s_clear),
    .new_lane_v (in_lane_v),
    .new_inst   (in_inst),
    .new_pc     (in_pc),
    .valid      (s_valid),
    .lane_v     (s_lane_v),
    .inst       (s_inst),
    .pc         (s_pc)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating stall/flush counters; only Reset clears them, not flush.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (m_valid && !emit && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush && (m_valid || s_valid) && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with two lanes and 4-bit counters.
// Counter expectations follow PIPE_STAGE_PERF_EN (zero when undefined).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int LANES = 2;
  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_v;
  logic [63:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane_v;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic        hold;
  logic        flush;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  int checks = 0;
  int fails  = 0;

  pipe_stage_reg #(
    .INST_W (32),
    .PC_W   (32),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (clk),
    .Reset      (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lane_v  (in_lane_v),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lane_v (out_lane_v),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .hold       (hold),
    .flush      (flush),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane 0 carries the base PC; lane 1 is tagged so the packing is visible.
  function automatic logic [63:0] beatInst(input logic [31:0] pc);
    return {32'hB000_0000 | pc, 32'hA000_0000 | pc};
  endfunction

  function automatic logic [63:0] beatPc(input logic [31:0] pc);
    return {32'h1000_0000 | pc, pc};
  endfunction

  function automatic logic [3:0] expCnt(input logic [3:0] v);
    return PERF ? v : 4'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] pc,
                           input logic [1:0] lv);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".pc"}, out_pc, beatPc(pc));
    checkOutput({tag, ".inst"}, out_inst, beatInst(pc));
    checkOutput({tag, ".lane_v"}, 64'(out_lane_v), 64'(lv));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, ".inst"}, out_inst, 64'd0);
    checkOutput({tag, ".pc"}, out_pc, 64'd0);
    checkOutput({tag, ".lane_v"}, 64'(out_lane_v), 64'd0);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [1:0] lv, input logic rdy,
                               input logic hld, input logic fl);
    in_valid  = v;
    in_inst   = v ? beatInst(pc) : 64'd0;
    in_pc     = v ? beatPc(pc) : 64'd0;
    in_lane_v = v ? lv : 2'b00;
    out_ready = rdy;
    hold      = hld;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_lane_v = 2'b00;
    in_inst   = 64'd0;
    in_pc     = 64'd0;
    out_ready = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;

    $display("[TB] reset sequence");
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkIdle("reset");
    checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset.stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("reset.flush_cnt", 64'(flush_cnt), 64'd0);

    $display("[TB] streaming");
    for (int k = 0; k < 4; k++) begin
      logic [1:0] lv;
      lv = (k % 2 == 0) ? 2'b11 : 2'b01;
      applyStimulus(1'b1, 32'(k * 4), lv, 1'b1, 1'b0, 1'b0);
      checkBeat($sformatf("stream%0d", k), 32'(k * 4), lv);
      checkOutput($sformatf("stream%0d.in_ready", k), 64'(in_ready), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkIdle("stream_drain");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0);
    checkBeat("bp0", 32'h0, 2'b11);
    applyStimulus(1'b1, 32'h4, 2'b01, 1'b1, 1'b0, 1'b0);
    checkBeat("bp4", 32'h4, 2'b01);
    applyStimulus(1'b1, 32'h8, 2'b10, 1'b0, 1'b0, 1'b0);
    checkBeat("bp_park8", 32'h4, 2'b01);
    checkOutput("bp_park8.in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'hC, 2'b11, 1'b0, 1'b0, 1'b0);
    checkBeat("bp_refuseC", 32'h4, 2'b01);
    checkOutput("bp_refuseC.in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'hC, 2'b11, 1'b1, 1'b0, 1'b0);
    checkBeat("bp_out8", 32'h8, 2'b10);
    checkOutput("bp_out8.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'hC, 2'b11, 1'b1, 1'b0, 1'b0);
    checkBeat("bp_outC", 32'hC, 2'b11);
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkIdle("bp_drain");

    $display("[TB] hold");
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h10, 2'b11, 1'b1, 1'b0, 1'b0);
    checkBeat("hold_load", 32'h10, 2'b11);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
      checkBeat($sformatf("hold%0d", k), 32'h10, 2'b11);
    end
    checkOutput("hold.stall_cnt", 64'(stall_cnt), 64'(expCnt(4'd3)));

    $display("[TB] flush in FULL");
    applyStimulus(1'b1, 32'h14, 2'b11, 1'b1, 1'b1, 1'b0);
    checkBeat("fill_full", 32'h10, 2'b11);
    checkOutput("fill_full.in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h18, 2'b11, 1'b1, 1'b0, 1'b1);
    checkIdle("flush");
    checkOutput("flush.in_ready", 64'(in_ready), 64'd1);
    checkOutput("flush.flush_cnt", 64'(flush_cnt), 64'(expCnt(4'd1)));
    checkOutput("flush.stall_cnt", 64'(stall_cnt), 64'(expCnt(4'd4)));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkIdle("post_flush");

    $display("[TB] saturation");
    applyStimulus(1'b1, 32'h20, 2'b01, 1'b0, 1'b0, 1'b0);
    checkBeat("sat_load", 32'h20, 2'b01);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkBeat("sat_hold", 32'h20, 2'b01);
    checkOutput("sat.stall_cnt", 64'(stall_cnt), 64'(expCnt(4'hF)));

    $display("[TB] flush ignores hold, empty flush not counted");
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    checkIdle("flush_hold");
    checkOutput("flush_hold.flush_cnt", 64'(flush_cnt), 64'(expCnt(4'd2)));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_empty.flush_cnt", 64'(flush_cnt), 64'(expCnt(4'd2)));
    checkOutput("flush_empty.stall_cnt", 64'(stall_cnt), 64'(expCnt(4'hF)));

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("final_reset.stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("final_reset.flush_cnt", 64'(flush_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
